// File: rtl/bitty_fetch.sv
// ============================================================================
// Module   : bitty_fetch
// Brief    : Instruction prefetch stage feeding the bitty core from a req/ack
//            memory port through a small FIFO. Optional BITTY_FETCH_COUNT_EN
//            adds a retired-instruction counter output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bitty_fetch #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DEPTH      = 4,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              run,
  output logic [15:0]       d_instr,
  input  logic              done,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
`ifdef BITTY_FETCH_COUNT_EN
  output logic [15:0]       retired_cnt,
`endif
  output logic              underrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  exec_pc_q, exec_pc_d;
  logic               mem_req_q, mem_req_d;
  logic               run_q, run_d;
  logic               underrun_q, underrun_d;
  logic [15:0]        fifo_q [DEPTH];
  logic [CNT_W:0]     avail;
`ifdef BITTY_FETCH_COUNT_EN
  logic [15:0]        retired_q, retired_d;
`endif

  logic push, pop_req, pop;

  // Acks outside an outstanding request are ignored so a full FIFO can never be overwritten.
  assign push    = mem_req_q && mem_ack;
  assign pop_req = done && (state_q == S_RUN);
  assign pop     = pop_req && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    exec_pc_d  = exec_pc_q;
    mem_req_d  = 1'b0;
    run_d      = 1'b0;
    underrun_d = underrun_q;
    avail      = {1'b0, count_q} + {{CNT_W{1'b0}}, push};
`ifdef BITTY_FETCH_COUNT_EN
    retired_d  = retired_q;
`endif

    if (state_q != S_IDLE) begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        exec_pc_d = exec_pc_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Flag when the core's next fetch would find nothing at the head.
    if (pop_req && (avail <= (CNT_W+1)'(1))) underrun_d = 1'b1;
`ifdef BITTY_FETCH_COUNT_EN
    if (pop_req) retired_d = retired_q + 16'd1;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FILL;
          count_d    = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          fetch_pc_d = START_ADDR;
          exec_pc_d  = START_ADDR;
          underrun_d = 1'b0;
`ifdef BITTY_FETCH_COUNT_EN
          retired_d  = '0;
`endif
        end
      end
      S_FILL: begin
        if (count_q == CNT_W'(DEPTH)) begin
          state_d = S_RUN;
          run_d   = 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // A pending request is held until acked; a new one goes out only if it will fit.
    if (state_d != S_IDLE) begin
      if (mem_req_q && !mem_ack) mem_req_d = 1'b1;
      else                       mem_req_d = (count_d < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= START_ADDR;
      exec_pc_q  <= START_ADDR;
      mem_req_q  <= 1'b0;
      run_q      <= 1'b0;
      underrun_q <= 1'b0;
`ifdef BITTY_FETCH_COUNT_EN
      retired_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      exec_pc_q  <= exec_pc_d;
      mem_req_q  <= mem_req_d;
      run_q      <= run_d;
      underrun_q <= underrun_d;
`ifdef BITTY_FETCH_COUNT_EN
      retired_q  <= retired_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = fetch_pc_q;
  assign run      = run_q;
  assign d_instr  = (count_q == '0) ? 16'h0000 : fifo_q[rd_ptr_q];
  assign pc_out   = exec_pc_q;
  assign busy     = (state_q == S_FILL) || (state_q == S_RUN);
  assign underrun = underrun_q;
`ifdef BITTY_FETCH_COUNT_EN
  assign retired_cnt = retired_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitty_fetch.sv
// ============================================================================
// Module   : tb_bitty_fetch
// Brief    : Directed self-checking bench for bitty_fetch (ADDR_W=3, DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bitty_fetch;

  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              run;
  logic [15:0]       d_instr;
  logic              done;
  logic [ADDR_W-1:0] pc_out;
  logic              busy;
  logic              underrun;
`ifdef BITTY_FETCH_COUNT_EN
  logic [15:0]       retired_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic              manual;
  logic              man_ack;
  logic              auto_ack = 1'b0;
  int                lat;
  int                lat_cnt = 0;
  logic [ADDR_W-1:0] acked [$];

  bitty_fetch #(.ADDR_W(ADDR_W), .DEPTH(4), .START_ADDR('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .run       (run),
    .d_instr   (d_instr),
    .done      (done),
    .pc_out    (pc_out),
    .busy      (busy),
`ifdef BITTY_FETCH_COUNT_EN
    .retired_cnt(retired_cnt),
`endif
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // ROM contents: word at address a is 16'h1000 + a.
  assign mem_rdata = 16'h1000 + {13'd0, mem_addr};
  assign mem_ack   = manual ? man_ack : auto_ack;

  // Auto memory: acks a request in the lat-th cycle after it is first seen.
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      auto_ack = 1'b0;
      lat_cnt  = 0;
    end else if (lat_cnt >= lat) begin
      auto_ack = 1'b1;
      lat_cnt  = 0;
    end else begin
      auto_ack = 1'b0;
      lat_cnt  = lat_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack) acked.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (run) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int  base;
    bit  seen;

    reset = 1'b1; start = 1'b0; done = 1'b0;
    manual = 1'b0; man_ack = 1'b0; lat = 1;

    // Reset state
    #3;
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_run",      {31'd0, run},      32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_pc_out",   {29'd0, pc_out},   32'd0);
    check("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
    check("rst_d_instr",  {16'd0, d_instr},  32'd0);
    tick(); tick();
    reset = 1'b0;

    // Asynchronous reset in the middle of a fill
    pulse_start();
    check("fill_busy", {31'd0, busy},    32'd1);
    check("fill_req",  {31'd0, mem_req}, 32'd1);
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("arst_mem_req",  {31'd0, mem_req},  32'd0);
    check("arst_busy",     {31'd0, busy},     32'd0);
    check("arst_run",      {31'd0, run},      32'd0);
    check("arst_underrun", {31'd0, underrun}, 32'd0);
    check("arst_pc_out",   {29'd0, pc_out},   32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Steady streaming with one-cycle ack latency; addresses and PC wrap at 8
    lat  = 1;
    base = acked.size();
    pulse_start();
    wait_run("t2_run_seen");
    check("t2_fill_acks", acked.size() - base, 32'd4);
    check("t2_head0",     {16'd0, d_instr}, 32'h1000);
    check("t2_pc0",       {29'd0, pc_out},  32'd0);
    tick();
    check("t2_run_single", {31'd0, run}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      pulse_done();
      check("t2_head", {16'd0, d_instr}, 32'h1000 + (k & 7));
      check("t2_pc",   {29'd0, pc_out},  k & 7);
      tick(); tick();
    end
    check("t2_underrun", {31'd0, underrun}, 32'd0);
    check("t2_ack_count_ok", {31'd0, (acked.size() - base) >= 12}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("t2_mem_addr", (acked.size() > base + i) ? {29'd0, acked[base+i]} : 32'hDEAD, i % 8);
    end
    pulse_start();
    check("t2_start_ign_busy", {31'd0, busy},   32'd1);
    check("t2_start_ign_pc",   {29'd0, pc_out}, 32'd4);
    check("t2_start_ign_head", {16'd0, d_instr}, 32'h1004);
`ifdef BITTY_FETCH_COUNT_EN
    check("t6_retired", {16'd0, retired_cnt}, 32'd12);
`endif

    // Slow memory: prefetch falls behind the core
    do_reset();
`ifdef BITTY_FETCH_COUNT_EN
    check("t6_retired_rst", {16'd0, retired_cnt}, 32'd0);
`endif
    lat = 6;
    pulse_start();
    wait_run("t3_run_seen");
    check("t3_head0", {16'd0, d_instr}, 32'h1000);
    seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pulse_done();
      if (k == 2) check("t3_no_underrun_early", {31'd0, underrun}, 32'd0);
      if (underrun && !seen) begin
        seen = 1'b1;
        check("t3_empty_head", {16'd0, d_instr}, 32'h0000);
      end
      tick(); tick();
    end
    check("t3_underrun_set", {31'd0, underrun}, 32'd1);
    repeat (5) tick();
    check("t3_underrun_sticky", {31'd0, underrun}, 32'd1);

    // Simultaneous push and pop with two entries held
    do_reset();
    manual  = 1'b1;
    man_ack = 1'b1;
    pulse_start();
    wait_run("t5_run_seen");
    man_ack = 1'b0;
    check("t5_head0", {16'd0, d_instr}, 32'h1000);
    pulse_done();
    tick();
    pulse_done();
    check("t5_head2", {16'd0, d_instr}, 32'h1002);
    check("t5_pc2",   {29'd0, pc_out},  32'd2);
    check("t5_req_pending", {31'd0, mem_req}, 32'd1);
    done    = 1'b1;
    man_ack = 1'b1;
    tick();
    done    = 1'b0;
    man_ack = 1'b0;
    check("t5_both_head", {16'd0, d_instr},  32'h1003);
    check("t5_both_pc",   {29'd0, pc_out},   32'd3);
    check("t5_both_unr",  {31'd0, underrun}, 32'd0);
    tick();
    pulse_done();
    check("t5_head4", {16'd0, d_instr},  32'h1004);
    check("t5_unr4",  {31'd0, underrun}, 32'd0);
    tick();
    pulse_done();
    check("t5_empty", {16'd0, d_instr},  32'h0000);
    check("t5_unr5",  {31'd0, underrun}, 32'd1);
    check("t5_pc5",   {29'd0, pc_out},   32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
